// File: rtl/lib_seat_expiry.sv
// Reading-room seat reservation keeper.
// Serves reserve/release requests over a valid/ready handshake. Once per minute tick it
// walks every seat and ages the held ones, freeing a seat when its hold time reaches zero.
// A rising edge on the timer's daily-reset level frees every seat.
module lib_seat_expiry #(
  parameter  int NUM_SEATS = 16,
  parameter  int HOLD_MIN  = 120,
  localparam int SEAT_W    = $clog2(NUM_SEATS),
  localparam int CNT_W     = $clog2(NUM_SEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [10:0]          time_in,
  input  logic                 rst_timer,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [SEAT_W-1:0]    req_seat,
  output logic                 resp_valid,
  output logic                 resp_ok,
  output logic [NUM_SEATS-1:0] seat_busy,
  output logic [CNT_W-1:0]     free_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam logic [9:0]        HOLD_VAL = 10'(HOLD_MIN);
  localparam logic [SEAT_W-1:0] LAST_IDX = SEAT_W'(NUM_SEATS - 1);
  localparam logic [CNT_W-1:0]  ALL_FREE = CNT_W'(NUM_SEATS);

  state_t            state;
  logic [10:0]       time_q;
  logic              rst_q;
  logic              loaded;
  logic              tick_pend;
  logic [SEAT_W-1:0] idx;
  logic [9:0]        remain [NUM_SEATS];

  logic tick;
  logic clr_edge;
  logic accept;
  logic seat_ok;

  // A tick is any change of the time word; nothing counts until time_q holds a real sample.
  assign tick      = loaded && (time_in != time_q);
  assign clr_edge  = rst_timer && !rst_q;
  // Requests wait while a clear or a sweep is due, so housekeeping always wins.
  assign req_ready = loaded && (state == IDLE) && !clr_edge && !tick_pend;
  assign accept    = req_valid && req_ready;
  assign seat_ok   = (int'(req_seat) < NUM_SEATS);

  // Sample the timer inputs every cycle for tick and daily-clear edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= '0;
      rst_q  <= 1'b0;
      loaded <= 1'b0;
    end else begin
      time_q <= time_in;
      rst_q  <= rst_timer;
      loaded <= 1'b1;
    end
  end

  // Control FSM together with the per-seat hold state and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_pend  <= 1'b0;
      idx        <= '0;
      seat_busy  <= '0;
      free_count <= ALL_FREE;
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      for (int i = 0; i < NUM_SEATS; i++) remain[i] <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_edge) begin
            state     <= CLEAR;
            tick_pend <= 1'b0;
          end else if (tick_pend) begin
            state     <= SWEEP;
            idx       <= '0;
            // A tick landing on the sweep-start cycle queues the next sweep.
            tick_pend <= tick;
          end else begin
            tick_pend <= tick;
            if (accept) begin
              resp_valid <= 1'b1;
              if (seat_ok) begin
                if (!req_op && !seat_busy[req_seat]) begin
                  seat_busy[req_seat] <= 1'b1;
                  remain[req_seat]    <= HOLD_VAL;
                  free_count          <= free_count - CNT_W'(1);
                  resp_ok             <= 1'b1;
                end else if (req_op && seat_busy[req_seat]) begin
                  seat_busy[req_seat] <= 1'b0;
                  remain[req_seat]    <= '0;
                  free_count          <= free_count + CNT_W'(1);
                  resp_ok             <= 1'b1;
                end
              end
            end
          end
        end

        CLEAR: begin
          seat_busy  <= '0;
          free_count <= ALL_FREE;
          tick_pend  <= 1'b0;
          for (int i = 0; i < NUM_SEATS; i++) remain[i] <= '0;
          state      <= IDLE;
        end

        SWEEP: begin
          if (clr_edge) begin
            // Daily clear aborts the walk and discards any queued tick.
            state     <= CLEAR;
            tick_pend <= 1'b0;
          end else begin
            if (tick) tick_pend <= 1'b1;
            if (seat_busy[idx]) begin
              if (remain[idx] <= 10'd1) begin
                remain[idx]    <= '0;
                seat_busy[idx] <= 1'b0;
                free_count     <= free_count + CNT_W'(1);
              end else begin
                remain[idx] <= remain[idx] - 10'd1;
              end
            end
            if (idx == LAST_IDX) state <= IDLE;
            else                 idx   <= idx + SEAT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
